seq_muldiv: RTL and testbench

Iterative unsigned multiply/divide unit for the 8-bit processor datapath. It takes its two operands straight from the register file's read ports (RD1/RD2) and runs a shift-add multiply or a restoring divide over WIDTH cycles. It then issues a single-cycle write-back (`wb_we`/`wb_addr`/`wb_data`) that drives the register file's WE3/A3/WD3. A start/busy handshake lets the control unit stall while an operation is in flight.

---
 rtl/seq_muldiv.sv | 164 ++++++++++++++++
 tb/tb_seq_muldiv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative unsigned multiply/divide unit with register-file write-back
//
// Purpose: shift-add multiply or restoring divide over WIDTH cycles, then a
// single-cycle write-back into the register file (WE3/A3/WD3).
//
// Ports:
//   clk      in   1       clock, all state on posedge
//   reset    in   1       synchronous, active-high
//   start    in   1       request, accepted only in IDLE
//   op       in   2       00 MULL, 01 MULH, 10 DIV, 11 REM
//   a        in   WIDTH   operand A / dividend (RD1)
//   b        in   WIDTH   operand B / divisor  (RD2)
//   dst      in   ADDR_W  destination register
//   busy     out  1       high in RUN and WB
//   wb_we    out  1       one-cycle write-enable pulse
//   wb_addr  out  ADDR_W  write-back address (held until next WB)
//   wb_data  out  WIDTH   write-back data (held until next WB)
//   dbz      out  1       divide-by-zero, pulses with wb_we

module seq_muldiv #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              dbz
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [WIDTH-1:0]    b_q, b_d;
  // Shared accumulator.
  //   multiply: [2W-1:W] product high half, [W-1:0] multiplier shifting out
  //             while product low bits shift in.
  //   divide:   [2W-1:W] partial remainder, [W-1:0] dividend shifting out
  //             while quotient bits shift in.
  logic [2*WIDTH-1:0]  acc_q, acc_d, acc_step;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0]    wb_data_q, wb_data_d;

  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH:0]      div_trial;

  // One iteration of either algorithm, selected by the latched op.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      mul_sum = mul_sum + {1'b0, b_q};
    end

    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, b_q};

    if (op_q[1]) begin
      // The partial remainder stays below the divisor, so a non-negative
      // trial result always fits in WIDTH bits and bit WIDTH is a pure sign.
      // With b=0 every trial succeeds: quotient all-ones, remainder = a.
      if (!div_trial[WIDTH]) begin
        acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry-out of the add becomes the new product MSB after the shift.
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dst_d     = dst_q;
    b_d       = b_q;
    acc_d     = acc_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          op_d    = op;
          dst_d   = dst;
          b_d     = b;
          acc_d   = {{WIDTH{1'b0}}, a};
        end
      end

      S_RUN: begin
        acc_d = acc_step;
        if (cnt_q == LAST_ITER) begin
          state_d   = S_WB;
          cnt_d     = '0;
          wb_addr_d = dst_q;
          // op[0] picks the upper half for both MULH and REM.
          wb_data_d = op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign wb_we   = (state_q == S_WB);
  assign dbz     = (state_q == S_WB) && op_q[1] && (b_q == '0);
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - self-checking bench for seq_muldiv

module tb_seq_muldiv;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [ADDR_W-1:0] dst;
  logic              busy;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              dbz;

  int n_cmp = 0;
  int n_bad = 0;

  seq_muldiv #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .dst     (dst),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .dbz     (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: operation result from plain arithmetic, timing as a
  // countdown of cycles until the unit is idle again.
  function automatic logic [7:0] ref_result(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'(x) * int'(y);
    case (o)
      2'd0:    ref_result = 8'(p % 256);
      2'd1:    ref_result = 8'(p / 256);
      2'd2:    ref_result = (y == 0) ? 8'hFF : 8'(int'(x) / int'(y));
      default: ref_result = (y == 0) ? x : 8'(int'(x) % int'(y));
    endcase
  endfunction

  int                m_left   = 0;
  logic              m_we     = 1'b0;
  logic              m_dbz    = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [WIDTH-1:0]  m_data   = '0;
  logic [ADDR_W-1:0] m_dst    = '0;
  logic [WIDTH-1:0]  m_res    = '0;
  logic              m_pdbz   = 1'b0;
  logic              model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left   <= 0;
      m_we     <= 1'b0;
      m_dbz    <= 1'b0;
      m_addr   <= '0;
      m_data   <= '0;
      model_ok <= 1'b1;
    end else if (m_left == 0) begin
      m_we  <= 1'b0;
      m_dbz <= 1'b0;
      if (start) begin
        m_left <= WIDTH + 1;
        m_dst  <= dst;
        m_res  <= ref_result(op, a, b);
        m_pdbz <= op[1] && (b == 0);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_we   <= 1'b1;
        m_dbz  <= m_pdbz;
        m_addr <= m_dst;
        m_data <= m_res;
      end else begin
        m_we  <= 1'b0;
        m_dbz <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_busy",    16'(busy),    16'(m_left != 0));
      check("cyc_wb_we",   16'(wb_we),   16'(m_we));
      check("cyc_dbz",     16'(dbz),     16'(m_dbz));
      check("cyc_wb_addr", 16'(wb_addr), 16'(m_addr));
      check("cyc_wb_data", 16'(wb_data), 16'(m_data));
    end
  end

  // Issues one op at the current posedge+1, checks hand-computed literals,
  // and returns at the next posedge+1. With poke set, start is re-asserted
  // with junk operands during RUN and during WB.
  task automatic do_op(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] d, input logic [7:0] exp_data, input logic exp_dbz,
                       input bit poke, input string nm);
    int we_at;
    int busy_n;
    bit done;
    we_at  = 0;
    busy_n = 0;
    done   = 0;
    start = 1'b1; op = o; a = av; b = bv; dst = d;
    @(posedge clk); #1;
    // Scramble operands after acceptance; the result must not move.
    start = 1'b0;
    a = ~av; b = bv + 8'd3; op = ~o; dst = ~d;
    for (int n = 1; n <= 30 && !done; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (wb_we && we_at == 0) begin
        we_at = n;
        check({nm, "_addr"}, 16'(wb_addr), 16'(d));
        check({nm, "_data"}, 16'(wb_data), 16'(exp_data));
        check({nm, "_dbz"},  16'(dbz),     16'(exp_dbz));
      end
      if (poke && (n == 3 || n == 9)) begin
        start = 1'b1; op = 2'd3; a = 8'hA5; b = 8'h03; dst = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (n > 1 && !busy) done = 1;
    end
    start = 1'b0;
    if (we_at == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no wb_we within 30 cycles", nm);
    end else begin
      check({nm, "_latency"}, 16'(we_at), 16'(9));
    end
    check({nm, "_busy_cycles"}, 16'(busy_n), 16'(9));
    @(posedge clk); #1;
  endtask

  initial begin
    int we_seen;
    reset = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; dst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    16'(busy),    16'(0));
    check("rst_wb_we",   16'(wb_we),   16'(0));
    check("rst_wb_addr", 16'(wb_addr), 16'(0));
    check("rst_wb_data", 16'(wb_data), 16'(0));
    check("rst_dbz",     16'(dbz),     16'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // start on the very first idle edge after reset
    do_op(2'd0, 8'd13,  8'd11, 3'd2, 8'h8F, 1'b0, 1'b0, "mull_13x11");
    do_op(2'd1, 8'd13,  8'd11, 3'd2, 8'h00, 1'b0, 1'b0, "mulh_13x11");
    do_op(2'd0, 8'd200, 8'd200, 3'd1, 8'h40, 1'b0, 1'b0, "mull_200x200");
    do_op(2'd1, 8'd200, 8'd200, 3'd3, 8'h9C, 1'b0, 1'b0, "mulh_200x200");
    do_op(2'd2, 8'd102, 8'd7,  3'd5, 8'h0E, 1'b0, 1'b0, "div_102_7");
    do_op(2'd3, 8'd102, 8'd7,  3'd5, 8'h04, 1'b0, 1'b0, "rem_102_7");
    do_op(2'd2, 8'd57,  8'd0,  3'd4, 8'hFF, 1'b1, 1'b0, "div_57_0");
    do_op(2'd3, 8'd57,  8'd0,  3'd4, 8'h39, 1'b1, 1'b0, "rem_57_0");
    do_op(2'd0, 8'd13,  8'd11, 3'd2, 8'h8F, 1'b0, 1'b1, "poke_mull");

    // reset four edges after the accepting edge
    start = 1'b1; op = 2'd0; a = 8'd200; b = 8'd200; dst = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",    16'(busy),    16'(0));
    check("abort_wb_we",   16'(wb_we),   16'(0));
    check("abort_wb_data", 16'(wb_data), 16'(0));
    reset = 1'b0;
    we_seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (wb_we) we_seen++;
    end
    check("abort_no_wb", 16'(we_seen), 16'(0));
    @(posedge clk); #1;
    do_op(2'd2, 8'd102, 8'd7, 3'd5, 8'h0E, 1'b0, 1'b0, "post_abort_div");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
